// File: rtl/processing_mem_pkg.sv
// processing_mem_pkg: shared state encoding, memory size default and address wrap helper
package processing_mem_pkg;
  typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;
  localparam int MEM_WORDS_DEFAULT = 10000;
  function automatic logic [31:0] wrap_inc(input logic [31:0] a, input logic [31:0] words);
    return (a + 32'd1 >= words) ? '0 : a + 32'd1;
  endfunction
endpackage

// File: rtl/processing_mem_stream_reader_if.sv
// processing_mem_stream_reader_if: command, memory port-2 and output stream signals of the reader
interface processing_mem_stream_reader_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 14
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [ADDR_W-1:0] cmd_addr;
  logic [ADDR_W-1:0] cmd_len;
  logic [ADDR_W-1:0] mem_address;
  logic              mem_chipselect;
  logic              mem_write;
  logic [DATA_W/8-1:0] mem_byteenable;
  logic              mem_clken;
  logic [DATA_W-1:0] mem_readdata;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_last;
  logic              busy;
  logic              done;
  modport master (
    input  cmd_valid, cmd_addr, cmd_len, mem_readdata, out_ready,
    output cmd_ready, mem_address, mem_chipselect, mem_write, mem_byteenable, mem_clken,
           out_valid, out_data, out_last, busy, done
  );
  modport slave (
    output cmd_valid, cmd_addr, cmd_len, mem_readdata, out_ready,
    input  cmd_ready, mem_address, mem_chipselect, mem_write, mem_byteenable, mem_clken,
           out_valid, out_data, out_last, busy, done
  );
endinterface

// File: rtl/proc_mem_sync_fifo.sv
// proc_mem_sync_fifo: synchronous FIFO with occupancy count
module proc_mem_sync_fifo #(
  parameter int W     = 17,
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic [W-1:0]  wdata,
  input  logic          pop,
  output logic [W-1:0]  rdata,
  output logic          empty,
  output logic [CW-1:0] count
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wp, rp;
  always_ff @(posedge clk)
    if (push) mem[wp] <= wdata;
  always_ff @(posedge clk) begin
    if (reset) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (push) wp <= wp + AW'(1);
      if (pop) rp <= rp + AW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end
  assign rdata = mem[rp];
  assign empty = count == '0;
endmodule

// File: rtl/processing_mem_stream_reader.sv
// processing_mem_stream_reader: streams a run of port-2 halfwords into a valid/ready output
module processing_mem_stream_reader import processing_mem_pkg::*; #(
  parameter int DATA_W     = 16,
  parameter int ADDR_W     = 14,
  parameter int MEM_WORDS  = MEM_WORDS_DEFAULT,
  parameter int FIFO_DEPTH = 4
) (
  input logic clk,
  input logic reset,
  processing_mem_stream_reader_if.master bus
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  state_t            state, state_n;
  logic [ADDR_W-1:0] addr, rem;
  logic              inflight, inflight_last, done_zero;
  logic              accept, issue, finish, empty;
  logic [CW-1:0]     count;
  logic [DATA_W:0]   head;
  // credit includes the read still in flight so the FIFO can never overflow
  always_comb begin
    accept  = state == IDLE && bus.cmd_valid;
    issue   = state == READ && (count + CW'(inflight)) < CW'(FIFO_DEPTH);
    finish  = state == DRAIN && empty && !inflight;
    state_n = (accept && bus.cmd_len != '0) ? READ :
              (issue && rem == ADDR_W'(1))  ? DRAIN :
              finish                        ? IDLE : state;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      addr          <= '0;
      rem           <= '0;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
      done_zero     <= 1'b0;
    end else begin
      state         <= state_n;
      inflight      <= issue;
      inflight_last <= issue && rem == ADDR_W'(1);
      done_zero     <= accept && bus.cmd_len == '0;
      if (accept) begin
        addr <= bus.cmd_addr;
        rem  <= bus.cmd_len;
      end else if (issue) begin
        addr <= ADDR_W'(wrap_inc(32'(addr), 32'(MEM_WORDS)));
        rem  <= rem - ADDR_W'(1);
      end
    end
  end
  proc_mem_sync_fifo #(.W(DATA_W + 1), .DEPTH(FIFO_DEPTH), .CW(CW)) fifo (
    .clk   (clk),
    .reset (reset),
    .push  (inflight),
    .wdata ({inflight_last, bus.mem_readdata}),
    .pop   (!empty && bus.out_ready),
    .rdata (head),
    .empty (empty),
    .count (count)
  );
  assign bus.cmd_ready      = state == IDLE;
  assign bus.busy           = state != IDLE;
  assign bus.done           = done_zero | finish;
  assign bus.mem_address    = addr;
  assign bus.mem_chipselect = issue;
  assign bus.mem_write      = 1'b0;
  assign bus.mem_byteenable = '1;
  assign bus.mem_clken      = 1'b1;
  assign bus.out_valid      = !empty;
  assign {bus.out_last, bus.out_data} = empty ? '0 : head;
endmodule

// File: tb/tb_processing_mem_stream_reader.sv
// tb_processing_mem_stream_reader: scoreboard bench with a queue-based reference model
module tb_processing_mem_stream_reader;
  localparam int DW = 16, AW = 14, MW = 10000, FD = 4;
  logic clk = 0, reset = 1;
  always #5 clk = ~clk;
  processing_mem_stream_reader_if #(.DATA_W(DW), .ADDR_W(AW)) bus();
  processing_mem_stream_reader #(.DATA_W(DW), .ADDR_W(AW), .MEM_WORDS(MW), .FIFO_DEPTH(FD)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );
  int vectors = 0, miscompares = 0;
  logic [DW-1:0] mem_model [MW];
  logic [DW:0]   beat_q [$];
  logic [AW-1:0] addr_q [$];
  longint cyc = 0, exp_done = -1, acc_cyc = 0, done_cyc = 0;
  bit first_pending = 0;
  int strobes = 0, beats = 0, ready_mode = 1;
  logic rst_d = 1, prev_valid = 0, prev_ready = 0, prev_last = 0;
  logic [DW-1:0] prev_data = 0;
  function automatic void chk(string name, longint got, longint want);
    vectors++;
    if (got != want) begin
      miscompares++;
      $display("FAIL %s: got %0h, wanted %0h (cycle %0d)", name, got, want, cyc);
    end
  endfunction
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk)
    bus.mem_readdata <= (bus.mem_chipselect && bus.mem_address < AW'(MW)) ? mem_model[bus.mem_address] : 16'hdead;
  always @(posedge clk) begin
    #1;
    bus.out_ready = ready_mode == 2 ? 1'($urandom_range(0, 1)) : ready_mode == 1;
  end
  // monitor: every observable output is checked against the model here
  always @(negedge clk) begin
    logic [DW:0] exp;
    if (reset) begin
      beat_q.delete();
      addr_q.delete();
      exp_done = -1;
      first_pending = 0;
    end else begin
      if (rst_d) begin
        chk("rst_flags", {bus.cmd_ready, bus.busy, bus.done, bus.mem_chipselect, bus.out_valid, bus.out_last}, 6'b100000);
        chk("rst_addr", bus.mem_address, 0);
        chk("rst_data", bus.out_data, 0);
      end
      chk("tieoffs", {bus.mem_write, bus.mem_clken, bus.mem_byteenable}, 4'b0111);
      chk("done", bus.done, cyc == exp_done);
      chk("busy", bus.busy, !bus.cmd_ready);
      if (bus.done) done_cyc = cyc;
      if (prev_valid && !prev_ready && !rst_d) begin
        chk("stall_valid", bus.out_valid, 1);
        chk("stall_hold", {bus.out_last, bus.out_data}, {prev_last, prev_data});
      end
      if (bus.mem_chipselect) begin
        strobes++;
        chk("strobe_pending", addr_q.size() > 0, 1);
        if (addr_q.size() > 0) chk("strobe_addr", bus.mem_address, addr_q.pop_front());
      end
      if (bus.out_valid && first_pending) begin
        chk("latency", cyc - acc_cyc, 3);
        first_pending = 0;
      end
      if (bus.out_valid && bus.out_ready) begin
        beats++;
        chk("beat_pending", beat_q.size() > 0, 1);
        if (beat_q.size() > 0) begin
          exp = beat_q.pop_front();
          chk("beat", {bus.out_last, bus.out_data}, exp);
          if (exp[DW]) exp_done = cyc + 1;
        end
      end
      if (bus.cmd_valid && bus.cmd_ready) begin
        acc_cyc = cyc;
        if (bus.cmd_len == 0) exp_done = cyc + 1;
        else first_pending = 1;
      end
    end
    rst_d      = reset;
    prev_valid = bus.out_valid;
    prev_ready = bus.out_ready;
    prev_last  = bus.out_last;
    prev_data  = bus.out_data;
  end
  task automatic send(input int a, input int len);
    int n = 0;
    for (int i = 0; i < len; i++) begin
      int ad = (a + i) % MW;
      addr_q.push_back(AW'(ad));
      beat_q.push_back({i == len - 1, mem_model[ad]});
    end
    @(posedge clk);
    #1;
    bus.cmd_valid = 1;
    bus.cmd_addr  = AW'(a);
    bus.cmd_len   = AW'(len);
    @(negedge clk);
    while (!bus.cmd_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("cmd_accepted", bus.cmd_ready, 1);
    @(posedge clk);
    #1;
    bus.cmd_valid = 0;
  endtask
  task automatic wait_done(input int budget);
    int n = 0;
    @(negedge clk);
    while (!bus.done && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("done_seen", bus.done, 1);
    @(negedge clk);
  endtask
  initial begin
    int s0, b0, n;
    for (int i = 0; i < MW; i++) mem_model[i] = DW'(i);
    bus.cmd_valid = 0;
    bus.cmd_addr  = 0;
    bus.cmd_len   = 0;
    repeat (3) @(posedge clk);
    #1 reset = 0;
    ready_mode = 1;
    send(16'h0010, 4);
    wait_done(50);
    chk("throughput_a", done_cyc - acc_cyc, 7);
    send(9998, 4);
    wait_done(50);
    chk("throughput_wrap", done_cyc - acc_cyc, 7);
    s0 = strobes;
    b0 = beats;
    send(16'h0100, 0);
    wait_done(10);
    chk("len0_strobes", strobes - s0, 0);
    chk("len0_beats", beats - b0, 0);
    ready_mode = 0;
    s0 = strobes;
    send(500, 8);
    repeat (10) @(negedge clk);
    chk("stall_strobes", strobes - s0, FD);
    ready_mode = 1;
    wait_done(100);
    chk("stall_total_strobes", strobes - s0, 8);
    b0 = beats;
    send(200, 6);
    n = 0;
    while (beats - b0 < 2 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("two_beats_before_reset", beats - b0 >= 2, 1);
    @(posedge clk);
    #1 reset = 1;
    @(posedge clk);
    #1 reset = 0;
    send(300, 2);
    wait_done(50);
    ready_mode = 2;
    send($urandom_range(0, MW - 1), 100);
    wait_done(2000);
    repeat (12) begin
      ready_mode = $urandom_range(1, 2);
      send($urandom_range(0, 1) ? $urandom_range(MW - 6, MW - 1) : $urandom_range(0, MW - 1), $urandom_range(0, 12));
      wait_done(500);
    end
    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, wanted completion");
    $fatal(1);
  end
endmodule

// File: doc/processing_mem_stream_reader.md
PROCESSING_MEM_STREAM_READER -- requirements
Module: processing_mem_stream_reader

Interface
REQ-001 SHALL have parameter DATA_W, default 16, meaning the port-2 read data width.
REQ-002 SHALL have parameter ADDR_W, default 14, meaning the port-2 halfword address width.
REQ-003 SHALL have parameter MEM_WORDS, default 10000, meaning the number of valid port-2 halfword locations.
REQ-004 SHALL have parameter FIFO_DEPTH, default 4 (power of 2, >=2), meaning the output buffer depth.
REQ-005 SHALL have one clock and a synchronous, active-high reset: clk  input  1  sole clock; reset  input  1  synchronous active-high reset.
REQ-006 SHALL have cmd_valid  input  1  command offered.
REQ-007 SHALL have cmd_ready  output  1  command accepted when high together with cmd_valid.
REQ-008 SHALL have cmd_addr  input  ADDR_W  start halfword address.
REQ-009 SHALL have cmd_len  input  ADDR_W  halfword count; 0 means an empty transfer.
REQ-010 SHALL have mem_address  output  ADDR_W  port-2 address.
REQ-011 SHALL have mem_chipselect  output  1  read strobe.
REQ-012 SHALL have mem_write  output  1  tied 0.
REQ-013 SHALL have mem_byteenable  output  DATA_W/8  tied all-ones.
REQ-014 SHALL have mem_clken  output  1  tied 1.
REQ-015 SHALL have mem_readdata  input  DATA_W  read data, valid exactly 1 cycle after the strobe.
REQ-016 SHALL have out_valid  output  1, out_ready  input  1, out_data  output  DATA_W, and out_last  output  1, forming the valid/ready stream.
REQ-017 SHALL have busy  output  1  transfer in progress, and done  output  1  one-cycle completion pulse.

Function
REQ-018 SHALL implement the states IDLE, READ and DRAIN.
REQ-019 In IDLE, cmd_ready SHALL be 1; on cmd_valid with cmd_len!=0, the block SHALL latch addr/len and go to READ next cycle.
REQ-020 cmd_valid with cmd_len==0 SHALL be accepted, produce no stream beats, pulse done the next cycle, and stay in IDLE.
REQ-021 In READ, mem_chipselect SHALL assert only when fifo_count + inflight < FIFO_DEPTH, where inflight (0/1) is a read issued in the previous cycle.
REQ-022 Each returned mem_readdata SHALL be written into the FIFO the cycle after its strobe, with a tag last=1 on the final halfword.
REQ-023 After each issued read, the address SHALL increment by 1, wrapping from MEM_WORDS-1 to 0; the remaining count SHALL decrement by 1.
REQ-024 When the remaining count reaches 0 after an issue, the block SHALL go to DRAIN; no further strobes SHALL be issued.
REQ-025 In DRAIN, when the FIFO is empty and inflight==0, the block SHALL pulse done for 1 cycle and return to IDLE.
REQ-026 out_valid SHALL equal FIFO not empty; out_data/out_last SHALL come from the FIFO head and SHALL be held stable while out_valid && !out_ready.
REQ-027 A simultaneous FIFO push and pop SHALL leave the count unchanged; a push into a full FIFO SHALL be impossible by REQ-021.
REQ-028 Minimum latency from command acceptance to first out_valid SHALL be 3 cycles; throughput SHALL be 1 beat/cycle with out_ready held at 1.
REQ-029 busy SHALL be 1 in READ and DRAIN and 0 in IDLE; cmd_ready SHALL be 0 while busy.

Reset
REQ-030 On reset: state=IDLE, cmd_ready=1, busy=0, done=0, mem_chipselect=0, mem_address=0, out_valid=0, out_last=0, out_data=0, FIFO emptied, inflight=0.
REQ-031 Reset mid-transfer SHALL abort the transfer without a done pulse; a read returning in the cycle after reset SHALL be discarded.

Structure
REQ-032 The state encoding and the MEM_WORDS default SHALL reside in shared package processing_mem_pkg.
REQ-033 The FIFO SHALL be a sub-module, proc_mem_sync_fifo (width DATA_W+1, depth FIFO_DEPTH, count output).

Verification
REQ-034 Command addr=0x0010, len=4, out_ready=1, with memory preloaded to value=address: beats 0x0010..0x0013, out_last on 4th beat, done 1 cycle after the last pop.
REQ-035 Command addr=9998, len=4: address sequence 9998, 9999, 0, 1; data matches.
REQ-036 Command len=8 with out_ready=0 for 10 cycles: exactly FIFO_DEPTH=4 strobes, then none; all 8 beats in order after release, with no loss or duplicate.
REQ-037 Command len=0: no strobe, no beat, done pulse 1 cycle after acceptance.
REQ-038 Reset asserted after 2 beats of a len=6 transfer: all outputs at reset values next cycle, no done pulse; a following len=2 transfer completes correctly.
REQ-039 Random out_ready at 50% over a len=100 transfer: 100 beats in order, mem_write never 1, out_data stable while stalled.
